// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter in front of one single-clock memory port.
// Requesters hand over read/write transactions with valid/ready. The winner is
// registered onto the memory port, and read data is routed back to the
// originating requester two cycles after acceptance.
module mem_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_data_in,
    output logic                          mem_write_en,
    input  logic [DATA_WIDTH-1:0]         mem_data_out
);

    localparam int                PTR_W    = $clog2(NUM_REQ);
    localparam logic [PTR_W:0]    NREQ_EXT = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NUM_REQ - 1);

    // Per-requester views of the flattened request buses
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;

    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] cand_idx;
    logic [PTR_W:0]   cand;
    logic             grant_any;
    logic             win_write;

    logic             rd_pend;
    logic [PTR_W-1:0] rd_tag;

    // Winner search: first valid requester starting at ptr, wrapping modulo NUM_REQ.
    // ptr is always < NUM_REQ, so one conditional subtraction keeps cand in range.
    always_comb begin
        grant_any = 1'b0;
        win_idx   = '0;
        cand      = '0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand >= NREQ_EXT)
                cand = cand - NREQ_EXT;
            cand_idx = cand[PTR_W-1:0];
            if (!grant_any && req_valid[cand_idx]) begin
                grant_any = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // One-hot ready to the winner; depends only on req_valid and ptr
    always_comb begin
        req_ready = '0;
        if (grant_any)
            req_ready[win_idx] = 1'b1;
    end

    // Every grant is an acceptance since the winner's valid is already high
    assign win_write = req_write[win_idx];

    // Round-robin pointer: moves just past the accepted requester, holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (grant_any)
            ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    end

    // Issue stage: register the accepted request onto the memory port and
    // remember which requester a read belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr     <= '0;
            mem_data_in  <= '0;
            mem_write_en <= 1'b0;
            rd_pend      <= 1'b0;
            rd_tag       <= '0;
        end else if (grant_any) begin
            mem_addr     <= addr_v[win_idx];
            mem_data_in  <= wdata_v[win_idx];
            mem_write_en <= win_write;
            rd_pend      <= !win_write;
            if (!win_write)
                rd_tag <= win_idx;
        end else begin
            mem_write_en <= 1'b0;
            rd_pend      <= 1'b0;
        end
    end

    // Response stage, one register per requester lane: fires the cycle the
    // memory read data appears on mem_data_out
    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_rsp
            logic rsp_q;

            // Lane g claims the response when the pending read carries its tag
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    rsp_q <= 1'b0;
                else
                    rsp_q <= rd_pend && (rd_tag == PTR_W'(g));
            end

            assign rsp_valid[g] = rsp_q;
        end
    endgenerate

    // Read data is shared by all requesters and qualified by rsp_valid
    assign rsp_rdata = mem_data_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by randomized traffic, checked
// against a transaction-level model (round-robin rule, shadow memory, per-cycle
// expectation tables).
module tb_mem_port_arbiter;

    localparam int N   = 4;
    localparam int AW  = 6;
    localparam int DW  = 14;
    localparam int MAXC = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_write = '0;
    logic [N*AW-1:0]   req_addr  = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_data_in;
    logic              mem_write_en;
    logic [DW-1:0]     mem_data_out;

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // 64x14 single-clock memory sitting on the port, with a preload path
    logic [DW-1:0] mem [64];
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_a  = '0;
    logic [DW-1:0] pl_d  = '0;

    always @(posedge clk) begin
        if (pl_we)
            mem[pl_a] <= pl_d;
        else if (mem_write_en)
            mem[mem_addr] <= mem_data_in;
        mem_data_out <= mem[mem_addr];
    end

    // Reference model state
    logic [DW-1:0] ref_mem [64];
    int            mptr;
    int            cyc;
    int            last_win;
    logic [N-1:0]  obs_ready;
    bit [N-1:0]    exp_rv  [MAXC];
    bit [DW-1:0]   exp_rd  [MAXC];
    bit            exp_wen [MAXC];
    bit            exp_iss [MAXC];
    bit [AW-1:0]   exp_ma  [MAXC];
    bit [DW-1:0]   exp_md  [MAXC];
    int            waitc   [N];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec rule: first valid requester searching ptr, ptr+1, ... mod N
    function automatic int model_winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N] === 1'b1)
                return (p + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]           = v;
        req_write[i]           = wr;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    // One clock: check outputs at negedge against the model, log the acceptance,
    // then advance to just after the next posedge
    task automatic run_cycle();
        int            win;
        logic [N-1:0]  exp_ready;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        obs_ready = req_ready;
        win = model_winner(req_valid, mptr);
        exp_ready = '0;
        if (win >= 0)
            exp_ready[win] = 1'b1;
        chk("req_ready", req_ready, exp_ready);
        chk("rsp_valid", rsp_valid, exp_rv[cyc]);
        if (exp_rv[cyc] != '0)
            chk("rsp_rdata", rsp_rdata, exp_rd[cyc]);
        chk("mem_write_en", mem_write_en, exp_wen[cyc]);
        if (exp_iss[cyc]) begin
            chk("mem_addr", mem_addr, exp_ma[cyc]);
            if (exp_wen[cyc])
                chk("mem_data_in", mem_data_in, exp_md[cyc]);
        end
        last_win = win;
        if (win >= 0) begin
            a = req_addr[win*AW +: AW];
            d = req_wdata[win*DW +: DW];
            exp_iss[cyc+1] = 1'b1;
            exp_ma[cyc+1]  = a;
            exp_wen[cyc+1] = req_write[win];
            if (req_write[win]) begin
                ref_mem[a]    = d;
                exp_md[cyc+1] = d;
            end else begin
                exp_rv[cyc+2]      = '0;
                exp_rv[cyc+2][win] = 1'b1;
                exp_rd[cyc+2]      = ref_mem[a];
            end
            mptr = (win + 1) % N;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_winner();
        if (last_win >= 0)
            req_valid[last_win] = 1'b0;
    endtask

    task automatic flush(input int n);
        for (int k = 0; k < n; k++)
            run_cycle();
    endtask

    // Asynchronous reset pulse in the middle of a cycle; in-flight work is lost
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_wen", mem_write_en, 1'b0);
        chk("rst_rsp", rsp_valid, '0);
        chk("rst_ready", req_ready, '0);
        chk("rst_maddr", mem_addr, '0);
        #1;
        rst = 1'b0;
        for (int c = cyc; c < MAXC; c++) begin
            exp_rv[c]  = '0;
            exp_wen[c] = 1'b0;
            exp_iss[c] = 1'b0;
        end
        mptr = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        mptr = 0;
        cyc = 0;
        last_win = -1;
        // Preload the memory under reset
        for (int a = 0; a < 64; a++) begin
            v = DW'($urandom);
            if (a == 5)  v = 14'h1234;
            if (a >= 10 && a <= 13) v = DW'(14'h0100 + a);
            pl_we = 1'b1;
            pl_a  = AW'(a);
            pl_d  = v;
            ref_mem[a] = v;
            @(posedge clk);
            #1;
        end
        pl_we = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_ready", req_ready, '0);
        chk("reset_rsp", rsp_valid, '0);
        chk("reset_wen", mem_write_en, 1'b0);
        chk("reset_maddr", mem_addr, '0);
        chk("reset_mdin", mem_data_in, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single read: requester 2 reads addr 5
        set_req(2, 1'b1, 1'b0, 6'd5, '0);
        run_cycle();
        chk("single_ready", obs_ready, 4'b0100);
        clear_winner();

        // Pointer skip and wrap: ptr=3, only 1 and 3 valid
        set_req(1, 1'b1, 1'b0, 6'd20, '0);
        set_req(3, 1'b1, 1'b0, 6'd21, '0);
        run_cycle();
        chk("skip_first", obs_ready, 4'b1000);
        clear_winner();
        run_cycle();
        chk("skip_second", obs_ready, 4'b0010);
        clear_winner();
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, 1'b0, AW'(30 + i), '0);
        run_cycle();
        chk("ptr_end", obs_ready, 4'b0100);
        req_valid = '0;
        flush(3);

        // Write then read of addr 63 by requester 0
        set_req(0, 1'b1, 1'b1, 6'd63, 14'h2AAA);
        run_cycle();
        clear_winner();
        set_req(0, 1'b1, 1'b0, 6'd63, '0);
        run_cycle();
        clear_winner();
        flush(3);

        // Round-robin fairness from reset release
        do_reset();
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, 1'b0, AW'(10 + i), '0);
        for (int k = 0; k < 6; k++) begin
            run_cycle();
            chk("rr_order", obs_ready, 32'(1 << (k % N)));
        end
        req_valid = '0;
        flush(3);

        // Reset mid-flight: read accepted, reset in the next cycle
        set_req(1, 1'b1, 1'b0, 6'd7, '0);
        run_cycle();
        clear_winner();
        do_reset();
        flush(3);

        // Idle and drop: 0 granted, 3 drops before its turn
        set_req(0, 1'b1, 1'b0, 6'd8, '0);
        set_req(3, 1'b1, 1'b1, 6'd9, 14'h0555);
        run_cycle();
        chk("drop_grant0", obs_ready, 4'b0001);
        req_valid = '0;
        flush(4);

        // Randomized traffic with starvation bound
        for (int i = 0; i < N; i++)
            waitc[i] = 0;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        set_req(i, 1'b1, 1'($urandom_range(0, 1)),
                                AW'($urandom_range(0, 7)), DW'($urandom));
                        waitc[i] = 0;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            run_cycle();
            for (int i = 0; i < N; i++) begin
                if (i == last_win) begin
                    chk("starve_bound", 32'(waitc[i] < N), 1);
                    req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    waitc[i]++;
                end
            end
        end
        req_valid = '0;
        flush(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one port of the 64x14 single-clock memory between NUM_REQ requesters. Each requester issues read or write transactions over a valid/ready handshake. The arbiter registers the winning request onto the memory port and routes the read data back to the originating requester two cycles after acceptance. It sits directly in front of a memory port (addr / data_in / write_en / data_out) and is the only driver of that port.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 6, memory address width
- DATA_WIDTH, 14, memory word width
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester transaction request
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- rsp_valid  out  NUM_REQ  read data valid for requester i; one-hot or zero
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters, qualified by rsp_valid
- mem_addr  out  ADDR_WIDTH  memory port address (registered)
- mem_data_in  out  DATA_WIDTH  memory port write data (registered)
- mem_write_en  out  1  memory port write enable (registered)
- mem_data_out  in  DATA_WIDTH  memory port read data; valid the cycle after mem_addr is sampled

## Operation
- Grant:
  - Combinational from req_valid and the round-robin pointer ptr.
  - Winner is the first requester with req_valid=1, searching ptr, ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1; all other req_ready bits are 0.
  - No req_valid set -> req_ready=0.
  - req_ready never depends on anything other than req_valid and registered state.
- Handshake:
  - A transaction is accepted on a cycle where req_valid[i] and req_ready[i] are both 1.
  - The requester holds valid, write, addr and wdata stable until accepted.
  - A requester may drop valid before acceptance; the arbiter tolerates this.
- Pointer:
  - On acceptance by requester i, ptr <= (i+1) mod NUM_REQ.
  - With no acceptance, ptr holds.
  - Reset value: 0.
- Issue stage (registered):
  - On acceptance: mem_addr <= req_addr[i], mem_data_in <= req_wdata[i], mem_write_en <= req_write[i].
  - On a read acceptance, also record the tag (rd_pend <= 1, rd_tag <= i).
  - Without acceptance: mem_write_en <= 0 and rd_pend <= 0; mem_addr and mem_data_in hold.
- Response stage (registered):
  - rsp_valid <= one-hot(rd_tag) if rd_pend, else 0.
  - rsp_rdata is driven combinationally from mem_data_out.
- Writes produce no response.
- Throughput: one accepted transaction per cycle, sustained. There is no back-pressure on responses; requesters must always accept rsp_valid.
- Ordering:
  - A read accepted in cycle N+1 after a write to the same address accepted in cycle N returns the new data.
  - The arbiter adds no hazard logic; the memory write lands before the read address is sampled.

## Timing
- Reset values: req_ready=0 (no valids during reset), rsp_valid=0, mem_write_en=0, mem_addr=0, mem_data_in=0, ptr=0, rd_pend=0, rd_tag=0.
- Cycle N: acceptance (req_valid & req_ready).
- Cycle N+1: mem_addr, mem_data_in and mem_write_en present the request. For a write, the memory commits at the end of N+1.
- Cycle N+2, reads only: rsp_valid[i]=1 and rsp_rdata = mem[addr] for exactly one cycle.
- Read latency is fixed at 2 cycles from acceptance. Write commit is 1 cycle after acceptance.
- Simultaneous events:
  - A response for one requester and acceptance for another in the same cycle are independent.
  - The same requester may be accepted in the cycle its earlier response is returned.
- Reset mid-operation:
  - Asynchronous assertion immediately clears mem_write_en, rd_pend, rsp_valid and ptr.
  - An in-flight write not yet committed is dropped.
  - An in-flight read returns no response.
- Wrap-around: ptr wraps from NUM_REQ-1 to 0, and the search order wraps the same way.
- Starvation bound: a requester holding valid is accepted within NUM_REQ cycles.

## Test plan
- Single read:
  - Stimulus: mem preloaded with mem[5]=14'h1234; requester 2 reads addr 5 in cycle 0.
  - Response: req_ready[2]=1 in cycle 0; mem_addr=5 in cycle 1; rsp_valid=4'b0100 and rsp_rdata=14'h1234 in cycle 2; nothing else asserted.
- Write then read:
  - Stimulus: requester 0 writes 14'h2AAA to addr 63 in cycle 0; requester 0 reads addr 63 in cycle 1.
  - Response: mem_write_en=1 only in cycle 1; rsp_valid[0]=1 and rsp_rdata=14'h2AAA in cycle 3.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold valid reads (addresses 10..13) continuously from reset release.
  - Response: grant order 0,1,2,3,0,1 on consecutive cycles; rsp_valid follows the same order two cycles later, with matching data.
- Pointer skip and wrap:
  - Stimulus: ptr=3 after requester 2 is accepted; only requesters 1 and 3 valid.
  - Response: 3 is accepted, then 1; ptr ends at 2.
- Reset mid-flight:
  - Stimulus: requester 1 read accepted in cycle 0; rst pulsed asynchronously in cycle 1.
  - Response: rsp_valid stays 0 throughout; after reset, ptr=0 and mem_write_en=0.
- Idle and drop:
  - Stimulus: requester 3 raises valid then drops it before being granted, while requester 0 is being granted.
  - Response: no transaction from 3 is issued; mem_write_en=0 and rsp_valid=0 on idle cycles.
